fir_mac_sequencer: RTL

Control sequencer for the time-multiplexed FIR datapath. It accepts one input sample per valid/ready handshake and writes it into a circular sample buffer. It then drives a single shared MAC through all TAPS products by generating sample-read and coefficient addresses plus accumulator control. It presents a completion handshake once the MAC pipeline has drained. It holds no sample or coefficient data itself; the buffer, coefficient ROM and MAC/accumulator sit beside it.

---
 rtl/fir_mac_sequencer_if.sv | 59 +++++
 rtl/fir_mac_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer_if.sv
// ----------------------------------------------------------------------------
// fir_mac_sequencer_if
//
// Bundles the sequencer's handshake and datapath-control signals.
//   master : the sequencer (drives in_ready, write/read/MAC control, out_valid)
//   slave  : the surrounding datapath and sample source/sink
//
// Signals
//   in_valid / in_ready    sample input handshake
//   wr_en/wr_addr/wr_zero  sample buffer write port control
//   rd_addr / coef_addr    sample buffer read and coefficient ROM addresses
//   mac_vld / mac_first    shared MAC issue and accumulator-load control
//   out_valid / out_ready  finished-output handshake
//   busy                   sequencer not idle
//   flush                  zero-fill request (only with FIR_SEQ_FLUSH_EN)
// ----------------------------------------------------------------------------
interface fir_mac_sequencer_if #(
  parameter int AW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          wr_zero;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] coef_addr;
  logic          mac_vld;
  logic          mac_first;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
`ifdef FIR_SEQ_FLUSH_EN
  logic          flush;

  modport master (
    input  in_valid, out_ready, flush,
    output in_ready, wr_en, wr_addr, wr_zero, rd_addr, coef_addr,
           mac_vld, mac_first, out_valid, busy
  );

  modport slave (
    output in_valid, out_ready, flush,
    input  in_ready, wr_en, wr_addr, wr_zero, rd_addr, coef_addr,
           mac_vld, mac_first, out_valid, busy
  );
`else
  modport master (
    input  in_valid, out_ready,
    output in_ready, wr_en, wr_addr, wr_zero, rd_addr, coef_addr,
           mac_vld, mac_first, out_valid, busy
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, wr_en, wr_addr, wr_zero, rd_addr, coef_addr,
           mac_vld, mac_first, out_valid, busy
  );
`endif
endinterface

// File: rtl/fir_mac_sequencer.sv
// ----------------------------------------------------------------------------
// fir_mac_sequencer
//
// Control sequencer for a time-multiplexed FIR. Accepts one sample per
// in_valid/in_ready handshake, writes it into a circular sample buffer, then
// walks a single shared MAC through all TAPS products (newest sample first
// against coefficient 0), waits MAC_LAT cycles for the MAC pipeline to drain
// and holds out_valid until out_ready. No sample or coefficient data passes
// through this block.
//
// Parameters
//   TAPS     number of taps, power of two 2..256
//   MAC_LAT  mac_vld-to-accumulator latency, 0..7
//   AW       buffer / ROM address width
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          fir_mac_sequencer_if.master (see interface header)
//
// Build option
//   FIR_SEQ_FLUSH_EN  adds the flush input and a FLUSH state that zero-fills
//                     the whole sample buffer and rewinds the write pointer.
// ----------------------------------------------------------------------------
module fir_mac_sequencer #(
  parameter int TAPS    = 32,
  parameter int MAC_LAT = 2,
  parameter int AW      = $clog2(TAPS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fir_mac_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_OUT
`ifdef FIR_SEQ_FLUSH_EN
    , S_FLUSH
`endif
  } state_e;

  localparam logic [AW-1:0] TAP_LAST   = AW'(TAPS - 1);
  localparam logic [2:0]    DRAIN_LAST = 3'((MAC_LAT > 0) ? (MAC_LAT - 1) : 0);

  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q,  wptr_d;
  logic [AW-1:0] base_q,  base_d;
  logic [AW-1:0] tap_q,   tap_d;
  logic [2:0]    drain_q, drain_d;

  // Registered MAC / status outputs, loaded from the next-state values so
  // they line up with the state they describe.
  logic          mac_vld_q,   mac_vld_d;
  logic          mac_first_q, mac_first_d;
  logic [AW-1:0] rd_addr_q,   rd_addr_d;
  logic [AW-1:0] coef_addr_q, coef_addr_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q,      busy_d;

  logic          flush_req;
  logic          accept;
  logic          run_d;

`ifdef FIR_SEQ_FLUSH_EN
  assign flush_req = bus.flush;
`else
  assign flush_req = 1'b0;
`endif

  // Flush wins over a simultaneous sample in IDLE.
  assign accept = (state_q == S_IDLE) & bus.in_valid & ~flush_req;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      base_q      <= '0;
      tap_q       <= '0;
      drain_q     <= '0;
      mac_vld_q   <= 1'b0;
      mac_first_q <= 1'b0;
      rd_addr_q   <= '0;
      coef_addr_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      base_q      <= base_d;
      tap_q       <= tap_d;
      drain_q     <= drain_d;
      mac_vld_q   <= mac_vld_d;
      mac_first_q <= mac_first_d;
      rd_addr_q   <= rd_addr_d;
      coef_addr_q <= coef_addr_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  // NOTE: every variable assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    base_d  = base_q;
    tap_d   = tap_q;
    drain_d = drain_q;

    case (state_q)
      S_IDLE: begin
`ifdef FIR_SEQ_FLUSH_EN
        if (flush_req) begin
          tap_d   = '0;
          state_d = S_FLUSH;
        end else
`endif
        if (accept) begin
          base_d  = wptr_q;
          wptr_d  = wptr_q + 1'b1;   // wraps naturally: TAPS is a power of two
          tap_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        tap_d = tap_q + 1'b1;
        if (tap_q == TAP_LAST) begin
          drain_d = '0;
          state_d = (MAC_LAT > 0) ? S_DRAIN : S_OUT;
        end
      end

      S_DRAIN: begin
        drain_d = drain_q + 3'd1;
        if (drain_q == DRAIN_LAST) begin
          state_d = S_OUT;
        end
      end

      S_OUT: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

`ifdef FIR_SEQ_FLUSH_EN
      S_FLUSH: begin
        tap_d = tap_q + 1'b1;
        if (tap_q == TAP_LAST) begin
          wptr_d  = '0;
          state_d = S_IDLE;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    bus.in_ready = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = wptr_q;
    bus.wr_zero  = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus.in_ready = ~flush_req;
        bus.wr_en    = accept;
      end
`ifdef FIR_SEQ_FLUSH_EN
      S_FLUSH: begin
        bus.wr_en    = 1'b1;
        bus.wr_zero  = 1'b1;
        bus.wr_addr  = tap_q;
      end
`endif
      default: ;
    endcase

    // Tap k reads the sample written k inputs ago; unsigned AW-bit
    // subtraction gives the circular wrap for free.
    run_d       = (state_d == S_RUN);
    mac_vld_d   = run_d;
    mac_first_d = run_d && (tap_d == '0);
    coef_addr_d = run_d ? tap_d : '0;
    rd_addr_d   = run_d ? (base_d - tap_d) : '0;
    out_valid_d = (state_d == S_OUT);
    busy_d      = (state_d != S_IDLE);
  end

  assign bus.mac_vld   = mac_vld_q;
  assign bus.mac_first = mac_first_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.coef_addr = coef_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

endmodule
